// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
// Central stall/flush sequencer for the PC, IF_ID, ID_EX and EX_MEM buffers.
// Handles load-use bubbles, taken-jump flushes, the extra memory cycle for
// 32-bit PC push/pop, and interrupt acceptance (drain, then inject INT).
//
// State updates happen on negedge clk, the same edge as the pipeline buffers.
// Outputs are decoded combinationally from the current state and inputs.
//
// Optional feature macro: HAZ_PERF_CNT_EN (adds stall_cnt / flush_cnt).
//
// Ports:
//   clk, reset            clock (negedge active), synchronous active-high reset
//   ext_int, int_en       level interrupt request and its enable flag
//   idex_mem_read/rdst    load in ID_EX and its destination register
//   ifid_rsrc/rdst        IF_ID source/destination registers
//   ifid_use_rsrc/rdst    IF_ID instruction reads those registers
//   jmp_taken             EX resolved a taken jump/call/ret
//   exmem_pc_push_pop     EX_MEM holds a 32-bit PC push/pop
//   pc_stall .. exmem_stall, ifid_flush, idex_flush   buffer controls
//   int_inject            ID forces INT into ID_EX this cycle
//   stall_cnt, flush_cnt  saturating event counters (HAZ_PERF_CNT_EN only)
//   state_o               current FSM state (debug)
module pipeline_hazard_ctrl #(
    parameter int unsigned DRAIN_CYCLES = 3,
    parameter int unsigned CNT_W        = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ext_int,
    input  logic       int_en,
    input  logic       idex_mem_read,
    input  logic [2:0] idex_rdst,
    input  logic [2:0] ifid_rsrc,
    input  logic [2:0] ifid_rdst,
    input  logic       ifid_use_rsrc,
    input  logic       ifid_use_rdst,
    input  logic       jmp_taken,
    input  logic       exmem_pc_push_pop,
    output logic       pc_stall,
    output logic       ifid_stall,
    output logic       ifid_flush,
    output logic       idex_stall,
    output logic       idex_flush,
    output logic       exmem_stall,
    output logic       int_inject,
`ifdef HAZ_PERF_CNT_EN
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt,
`endif
    output logic [2:0] state_o
);

    localparam int unsigned ST_W = 3;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAIN_CYCLES - 1);

    typedef enum logic [ST_W-1:0] {
        ST_RUN    = 3'd0,
        ST_LU     = 3'd1,
        ST_FLUSH  = 3'd2,
        ST_MEM2   = 3'd3,
        ST_DRAIN  = 3'd4,
        ST_INJECT = 3'd5
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             int_pend_q, int_pend_d;
    logic             load_use;
    logic             int_req;

    // Load in ID_EX feeds a register the IF_ID instruction reads.
    assign load_use = idex_mem_read &
                      ((ifid_use_rsrc & (ifid_rsrc == idex_rdst)) |
                       (ifid_use_rdst & (ifid_rdst == idex_rdst)));

    // Pending or newly arriving request; a request is latched even while stalled.
    assign int_req = int_pend_q | (ext_int & int_en);

    // State, drain counter and pending-interrupt registers.
    always_ff @(negedge clk) begin
        if (reset) begin
            state_q    <= ST_RUN;
            cnt_q      <= '0;
            int_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            int_pend_q <= int_pend_d;
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        int_pend_d  = int_req;
        pc_stall    = 1'b0;
        ifid_stall  = 1'b0;
        ifid_flush  = 1'b0;
        idex_stall  = 1'b0;
        idex_flush  = 1'b0;
        exmem_stall = 1'b0;
        int_inject  = 1'b0;
        state_o     = state_q;

        case (state_q)
            ST_RUN: begin
                cnt_d = '0;
                // Push/pop belongs to an older instruction, so it beats the
                // jump; the stall holds jmp_taken for re-evaluation.
                if (exmem_pc_push_pop) begin
                    state_d = ST_MEM2;
                end else if (jmp_taken) begin
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                    state_d    = ST_FLUSH;
                end else if (load_use) begin
                    state_d = ST_LU;
                end else if (int_req) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_LU: begin
                pc_stall   = 1'b1;
                ifid_stall = 1'b1;
                idex_flush = 1'b1;
                state_d    = ST_RUN;
            end
            ST_FLUSH: begin
                state_d = ST_RUN;
            end
            ST_MEM2: begin
                pc_stall    = 1'b1;
                ifid_stall  = 1'b1;
                idex_stall  = 1'b1;
                exmem_stall = 1'b1;
                // Resume a drain in progress with its counter intact.
                state_d     = int_req ? ST_DRAIN : ST_RUN;
            end
            ST_DRAIN: begin
                if (exmem_pc_push_pop) begin
                    pc_stall   = 1'b1;
                    ifid_stall = 1'b1;
                    idex_flush = 1'b1;
                    state_d    = ST_MEM2;
                end else if (jmp_taken) begin
                    // Redirect: PC must load the target, so no stall here.
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                    cnt_d      = '0;
                end else begin
                    pc_stall   = 1'b1;
                    ifid_stall = 1'b1;
                    idex_flush = 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        cnt_d      = '0;
                        int_pend_d = 1'b0;
                        state_d    = ST_INJECT;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_INJECT: begin
                int_inject = 1'b1;
                pc_stall   = 1'b1;
                ifid_stall = 1'b1;
                state_d    = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        // During reset both flushable buffers are held in reset.
        if (reset) begin
            pc_stall    = 1'b0;
            ifid_stall  = 1'b0;
            ifid_flush  = 1'b1;
            idex_stall  = 1'b0;
            idex_flush  = 1'b1;
            exmem_stall = 1'b0;
            int_inject  = 1'b0;
            state_o     = '0;
        end
    end

`ifdef HAZ_PERF_CNT_EN
    // Saturating stall / bubble event counters.
    always_ff @(negedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (pc_stall && (stall_cnt != 16'hFFFF)) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
            if (idex_flush && (flush_cnt != 16'hFFFF)) begin
                flush_cnt <= flush_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed, table-driven bench for pipeline_hazard_ctrl. Each table row gives
// one cycle of inputs plus the outputs and state expected in that cycle.
// Inputs change just after negedge; outputs are sampled at posedge.
module tb_pipeline_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset, ext_int, int_en, idex_mem_read;
    logic [2:0] idex_rdst, ifid_rsrc, ifid_rdst;
    logic       ifid_use_rsrc, ifid_use_rdst, jmp_taken, exmem_pc_push_pop;
    logic       pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush;
    logic       exmem_stall, int_inject;
    logic [2:0] state_o;
`ifdef HAZ_PERF_CNT_EN
    logic [15:0] stall_cnt, flush_cnt;
`endif

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.DRAIN_CYCLES(3), .CNT_W(2)) dut (
        .clk               (clk),
        .reset             (reset),
        .ext_int           (ext_int),
        .int_en            (int_en),
        .idex_mem_read     (idex_mem_read),
        .idex_rdst         (idex_rdst),
        .ifid_rsrc         (ifid_rsrc),
        .ifid_rdst         (ifid_rdst),
        .ifid_use_rsrc     (ifid_use_rsrc),
        .ifid_use_rdst     (ifid_use_rdst),
        .jmp_taken         (jmp_taken),
        .exmem_pc_push_pop (exmem_pc_push_pop),
        .pc_stall          (pc_stall),
        .ifid_stall        (ifid_stall),
        .ifid_flush        (ifid_flush),
        .idex_stall        (idex_stall),
        .idex_flush        (idex_flush),
        .exmem_stall       (exmem_stall),
        .int_inject        (int_inject),
`ifdef HAZ_PERF_CNT_EN
        .stall_cnt         (stall_cnt),
        .flush_cnt         (flush_cnt),
`endif
        .state_o           (state_o)
    );

    // Output vector: {pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_stall, int_inject}
    localparam logic [6:0] O_NONE = 7'b0000000;
    localparam logic [6:0] O_RST  = 7'b0010100;
    localparam logic [6:0] O_JF   = 7'b0010100;
    localparam logic [6:0] O_LU   = 7'b1100100;
    localparam logic [6:0] O_DR   = 7'b1100100;
    localparam logic [6:0] O_M2   = 7'b1101010;
    localparam logic [6:0] O_INJ  = 7'b1100001;

    localparam logic [2:0] S_RUN = 3'd0, S_LU = 3'd1, S_FL = 3'd2;
    localparam logic [2:0] S_M2 = 3'd3, S_DR = 3'd4, S_INJ = 3'd5;

    typedef struct {
        string      name;
        logic       rst, ext, en, jmp, pp, mr;
        logic [2:0] rd, rs, fd;
        logic       urs, urd;
        logic [6:0] eo;
        logic [2:0] es;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    task automatic add(input string n, input logic rst, input logic ext, input logic en,
                       input logic jmp, input logic pp, input logic mr,
                       input logic [2:0] rd, input logic [2:0] rs, input logic [2:0] fd,
                       input logic urs, input logic urd,
                       input logic [6:0] eo, input logic [2:0] es);
        vec_t v;
        v.name = n; v.rst = rst; v.ext = ext; v.en = en; v.jmp = jmp; v.pp = pp;
        v.mr = mr; v.rd = rd; v.rs = rs; v.fd = fd; v.urs = urs; v.urd = urd;
        v.eo = eo; v.es = es;
        vecs.push_back(v);
    endtask

    // Idle cycle with only int_en chosen.
    task automatic idle(input string n, input logic en, input logic [6:0] eo, input logic [2:0] es);
        add(n, 1'b0, 1'b0, en, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, eo, es);
    endtask

    task automatic drive(input vec_t v);
        reset = v.rst; ext_int = v.ext; int_en = v.en; jmp_taken = v.jmp;
        exmem_pc_push_pop = v.pp; idex_mem_read = v.mr; idex_rdst = v.rd;
        ifid_rsrc = v.rs; ifid_rdst = v.fd; ifid_use_rsrc = v.urs; ifid_use_rdst = v.urd;
    endtask

    task automatic check(input string n, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, got, exp);
        end
    endtask

    function automatic logic [6:0] outs();
        return {pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_stall, int_inject};
    endfunction

    initial begin
        int  n;
        bit  found;
        vec_t z;

        // Reset
        add("rst0", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_RST, S_RUN);
        add("rst1", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_RST, S_RUN);
        idle("run0", 0, O_NONE, S_RUN);
        // Load-use on Rsrc, then non-matching Rsrc, then on Rdst
        add("lu_det", 0, 0, 0, 0, 0, 1, 3'd3, 3'd3, 3'd0, 1, 0, O_NONE, S_RUN);
        idle("lu_st", 0, O_LU, S_LU);
        idle("lu_end", 0, O_NONE, S_RUN);
        add("lu_miss", 0, 0, 0, 0, 0, 1, 3'd3, 3'd4, 3'd0, 1, 0, O_NONE, S_RUN);
        idle("lu_miss2", 0, O_NONE, S_RUN);
        add("lud_det", 0, 0, 0, 0, 0, 1, 3'd5, 3'd0, 3'd5, 0, 1, O_NONE, S_RUN);
        idle("lud_st", 0, O_LU, S_LU);
        idle("lud_end", 0, O_NONE, S_RUN);
        // Jump
        add("jmp", 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, O_JF, S_RUN);
        idle("jmp_fl", 0, O_NONE, S_FL);
        idle("jmp_end", 0, O_NONE, S_RUN);
        // Push/pop together with jump: MEM2 first, then flush
        add("pp_jmp", 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, O_NONE, S_RUN);
        add("pp_m2", 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, O_M2, S_M2);
        add("pp_jf", 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, O_JF, S_RUN);
        idle("pp_fl", 0, O_NONE, S_FL);
        idle("pp_end", 0, O_NONE, S_RUN);
        // Masked interrupt
        add("int_mask", 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_NONE, S_RUN);
        idle("int_mask1", 0, O_NONE, S_RUN);
        idle("int_mask2", 0, O_NONE, S_RUN);
        // Interrupt: 3 drain cycles then inject
        add("int_req", 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, O_NONE, S_RUN);
        idle("int_dr0", 1, O_DR, S_DR);
        idle("int_dr1", 1, O_DR, S_DR);
        idle("int_dr2", 1, O_DR, S_DR);
        idle("int_inj", 1, O_INJ, S_INJ);
        idle("int_end0", 1, O_NONE, S_RUN);
        idle("int_end1", 1, O_NONE, S_RUN);
        // Interrupt with load-use, jump in drain cycle 2 restarts the count
        add("ilu_req", 0, 1, 1, 0, 0, 1, 3'd3, 3'd3, 3'd0, 1, 0, O_NONE, S_RUN);
        idle("ilu_lu", 1, O_LU, S_LU);
        idle("ilu_run", 1, O_NONE, S_RUN);
        idle("ilu_dr0", 1, O_DR, S_DR);
        add("ilu_jmp", 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, O_JF, S_DR);
        idle("ilu_dr_a", 1, O_DR, S_DR);
        idle("ilu_dr_b", 1, O_DR, S_DR);
        idle("ilu_dr_c", 1, O_DR, S_DR);
        idle("ilu_inj", 1, O_INJ, S_INJ);
        idle("ilu_end", 1, O_NONE, S_RUN);
        // Push/pop during drain: MEM2, then drain resumes
        add("ipp_req", 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, O_NONE, S_RUN);
        idle("ipp_dr0", 1, O_DR, S_DR);
        add("ipp_pp", 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, O_DR, S_DR);
        idle("ipp_m2", 1, O_M2, S_M2);
        idle("ipp_dr1", 1, O_DR, S_DR);
        idle("ipp_dr2", 1, O_DR, S_DR);
        idle("ipp_inj", 1, O_INJ, S_INJ);
        idle("ipp_end", 1, O_NONE, S_RUN);
        // Reset mid-drain drops the pending interrupt
        add("rsd_req", 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, O_NONE, S_RUN);
        idle("rsd_dr0", 1, O_DR, S_DR);
        add("rsd_rst", 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, O_RST, S_RUN);
        idle("rsd_run0", 1, O_NONE, S_RUN);
        idle("rsd_run1", 1, O_NONE, S_RUN);
        idle("rsd_run2", 1, O_NONE, S_RUN);

        foreach (vecs[i]) begin
            drive(vecs[i]);
            @(posedge clk);
            check({vecs[i].name, "_out"}, 32'(outs()), 32'(vecs[i].eo));
            check({vecs[i].name, "_st"}, 32'(state_o), 32'(vecs[i].es));
            @(negedge clk);
            #1;
        end

        // Single-cycle level request: inject must appear exactly 4 cycles later
        z = vecs[0];
        z.rst = 0; z.ext = 1; z.en = 1;
        drive(z);
        n = 0;
        found = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            if (int_inject) begin
                found = 1;
                break;
            end
            @(negedge clk);
            #1;
            ext_int = 0;
            n++;
        end
        check("lvl_found", 32'(found), 32'd1);
        check("lvl_latency", 32'(n), 32'd4);
        @(negedge clk);
        #1;

`ifdef HAZ_PERF_CNT_EN
        // Counters clear on reset and count one LU stall + bubble
        reset = 1;
        @(negedge clk);
        #1;
        reset = 0;
        @(posedge clk);
        check("cnt_rst_stall", 32'(stall_cnt), 32'd0);
        check("cnt_rst_flush", 32'(flush_cnt), 32'd0);
        @(negedge clk);
        #1;
        idex_mem_read = 1; idex_rdst = 3'd2; ifid_use_rsrc = 1; ifid_rsrc = 3'd2;
        @(negedge clk);
        #1;
        idex_mem_read = 0; ifid_use_rsrc = 0;
        @(posedge clk);
        check("cnt_lu_out", 32'(outs()), 32'(O_LU));
        @(negedge clk);
        #1;
        @(posedge clk);
        check("cnt_stall", 32'(stall_cnt), 32'd1);
        check("cnt_flush", 32'(flush_cnt), 32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
